line_cmd_sequencer: RTL and testbench

Command front end for the line engine. Consumes a stream of 32-bit drawing command words (colour set, single line, polyline, stop), holds colour and endpoint state, and drives the line engine's colour/point/trigger handshake one line at a time. It sits directly upstream of `LineEngine`. Its outputs connect one-to-one to `LE_color`, `LE_point`, `LE_color_valid`, `LE_point0_valid`, `LE_point1_valid` and `LE_trigger`, and it observes `LE_ready`.

---
 rtl/line_cmd_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_line_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer: command front end for the line engine.
// Decodes a 32-bit command stream (STOP / COLOR / LINE / POLYLINE), keeps the
// current colour and endpoint pair, and walks the engine through its
// colour -> point0 -> point1 -> trigger handshake one line at a time.
module line_cmd_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             LE_ready,
    output logic [31:0]      LE_color,
    output logic [19:0]      LE_point,
    output logic             LE_color_valid,
    output logic             LE_point0_valid,
    output logic             LE_point1_valid,
    output logic             LE_trigger,
    output logic             busy,
    output logic             done,
    output logic             bad_opcode,
    output logic [CNT_W-1:0] lines_drawn
);

    localparam logic [7:0] OP_STOP  = 8'h00;
    localparam logic [7:0] OP_COLOR = 8'h01;
    localparam logic [7:0] OP_LINE  = 8'h02;
    localparam logic [7:0] OP_POLY  = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_GET_P0,
        S_GET_P1,
        S_WAIT_RDY,
        S_SEND_C,
        S_SEND_P0,
        S_SEND_P1,
        S_TRIG,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       color_q, color_d;
    logic [19:0]       p0_q, p0_d;
    logic [19:0]       p1_q, p1_d;
    logic [7:0]        rem_q, rem_d;
    logic              poly_q, poly_d;
    logic [31:0]       le_color_q, le_color_d;
    logic [19:0]       le_point_q, le_point_d;
    logic              color_vld_q, color_vld_d;
    logic              p0_vld_q, p0_vld_d;
    logic              p1_vld_q, p1_vld_d;
    logic              trig_q, trig_d;
    logic              done_q, done_d;
    logic              bad_q, bad_d;
    logic [CNT_W-1:0]  lines_q, lines_d;

    logic              accept;
    logic [7:0]        opcode;
    logic [7:0]        poly_n;

    // Words are only taken while fetching an opcode or one of its operands;
    // there is no buffering anywhere else.
    assign cmd_ready = (state_q == S_FETCH) || (state_q == S_GET_P0) ||
                       (state_q == S_GET_P1);
    assign accept    = cmd_valid && cmd_ready;
    assign opcode    = cmd_data[31:24];
    assign poly_n    = cmd_data[7:0];

    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign bad_opcode      = bad_q;
    assign lines_drawn     = lines_q;
    assign LE_color        = le_color_q;
    assign LE_point        = le_point_q;
    assign LE_color_valid  = color_vld_q;
    assign LE_point0_valid = p0_vld_q;
    assign LE_point1_valid = p1_vld_q;
    assign LE_trigger      = trig_q;

    // Next-state and next-output decode. Strobes are computed for the state
    // being entered so that each registered strobe coincides with its state.
    always_comb begin
        // NOTE: every signal written here gets its default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        color_d     = color_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        rem_d       = rem_q;
        poly_d      = poly_q;
        le_color_d  = le_color_q;
        le_point_d  = le_point_q;
        lines_d     = lines_q;
        bad_d       = bad_q;
        color_vld_d = 1'b0;
        p0_vld_d    = 1'b0;
        p1_vld_d    = 1'b0;
        trig_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (accept) begin
                    case (opcode)
                        OP_STOP: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                        OP_COLOR: begin
                            color_d = {8'h00, cmd_data[23:0]};
                        end
                        OP_LINE: begin
                            poly_d  = 1'b0;
                            state_d = S_GET_P0;
                        end
                        OP_POLY: begin
                            // N=0 carries no operands: stay and fetch again.
                            if (poly_n != 8'd0) begin
                                poly_d  = 1'b1;
                                rem_d   = poly_n - 8'd1;
                                state_d = S_GET_P0;
                            end
                        end
                        default: begin
                            bad_d = 1'b1;
                        end
                    endcase
                end
            end

            S_GET_P0: begin
                if (accept) begin
                    p0_d = cmd_data[19:0];
                    // A one-point polyline consumes its point and draws nothing.
                    if (!poly_q || (rem_q != 8'd0)) begin
                        state_d = S_GET_P1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_GET_P1: begin
                if (accept) begin
                    p1_d    = cmd_data[19:0];
                    state_d = S_WAIT_RDY;
                    if (poly_q) begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end

            S_WAIT_RDY: begin
                if (LE_ready) begin
                    state_d     = S_SEND_C;
                    le_color_d  = color_q;
                    color_vld_d = 1'b1;
                end
            end

            S_SEND_C: begin
                state_d    = S_SEND_P0;
                le_point_d = p0_q;
                p0_vld_d   = 1'b1;
            end

            S_SEND_P0: begin
                state_d    = S_SEND_P1;
                le_point_d = p1_q;
                p1_vld_d   = 1'b1;
            end

            S_SEND_P1: begin
                state_d = S_TRIG;
                trig_d  = 1'b1;
                lines_d = lines_q + CNT_W'(1);
            end

            S_TRIG: begin
                state_d = S_HOLD;
            end

            // The engine may still show ready for a cycle after the trigger,
            // so ready is not looked at here.
            S_HOLD: begin
                state_d = S_DRAIN;
            end

            S_DRAIN: begin
                if (LE_ready) begin
                    if (poly_q && (rem_q != 8'd0)) begin
                        p0_d    = p1_q;
                        state_d = S_GET_P1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-line
    // drops the handshake on the next edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q     <= S_IDLE;
            color_q     <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            rem_q       <= '0;
            poly_q      <= 1'b0;
            le_color_q  <= '0;
            le_point_q  <= '0;
            color_vld_q <= 1'b0;
            p0_vld_q    <= 1'b0;
            p1_vld_q    <= 1'b0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            rem_q       <= rem_d;
            poly_q      <= poly_d;
            le_color_q  <= le_color_d;
            le_point_q  <= le_point_d;
            color_vld_q <= color_vld_d;
            p0_vld_q    <= p0_vld_d;
            p1_vld_q    <= p1_vld_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            bad_q       <= bad_d;
            lines_q     <= lines_d;
        end
    end

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Bench for line_cmd_sequencer: directed command streams, a simple line
// engine model for LE_ready, and a scoreboard of expected lines checked by a
// monitor on every trigger. A second instance with a 2-bit counter shares the
// stimulus to exercise wrap-around.
module tb_line_cmd_sequencer;

    typedef struct packed {
        logic [31:0] color;
        logic [19:0] p0;
        logic [19:0] p1;
    } line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        force_low = 1'b0;
    logic        eng_busy  = 1'b0;
    logic        le_ready;

    logic        cmd_ready, cmd_ready2;
    logic [31:0] LE_color, LE_color2;
    logic [19:0] LE_point, LE_point2;
    logic        LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger;
    logic        cv2, p0v2, p1v2, trg2;
    logic        busy, busy2, done, done2, bad_opcode, bad2;
    logic [15:0] lines_drawn;
    logic [1:0]  lines_drawn2;

    int n_cmp = 0, n_fail = 0;
    int n_done = 0, exp_done = 0, n_acc = 0, n_sent = 0;
    int exp_lines = 0, cyc = 0, eng_cycles = 20;
    int t_c = 0, t_0 = 0, t_1 = 0;
    logic [31:0] cap_color;
    logic [19:0] cap_p0, cap_p1;
    logic        rdy_q = 1'b0;
    line_t       exp_q[$];

    always #5 clk = ~clk;
    assign le_ready = ~force_low & ~eng_busy;

    line_cmd_sequencer #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .LE_ready(le_ready),
        .LE_color(LE_color), .LE_point(LE_point),
        .LE_color_valid(LE_color_valid), .LE_point0_valid(LE_point0_valid),
        .LE_point1_valid(LE_point1_valid), .LE_trigger(LE_trigger),
        .busy(busy), .done(done), .bad_opcode(bad_opcode),
        .lines_drawn(lines_drawn)
    );

    line_cmd_sequencer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .cmd_data(cmd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .LE_ready(le_ready),
        .LE_color(LE_color2), .LE_point(LE_point2),
        .LE_color_valid(cv2), .LE_point0_valid(p0v2),
        .LE_point1_valid(p1v2), .LE_trigger(trg2),
        .busy(busy2), .done(done2), .bad_opcode(bad2),
        .lines_drawn(lines_drawn2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [19:0] pt(input int x, input int y);
        return {x[9:0], y[9:0]};
    endfunction

    // Cycle counter, ready history at the edge, handshake counter.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_q <= le_ready;
        if (!rst && cmd_valid && cmd_ready) n_acc <= n_acc + 1;
    end

    // Line engine model: drops ready for eng_cycles after each trigger.
    initial begin
        forever begin
            @(negedge clk);
            if (LE_trigger && !rst) begin
                eng_busy = 1'b1;
                repeat (eng_cycles) @(negedge clk);
                eng_busy = 1'b0;
            end
        end
    end

    // Monitor: captures strobes and scores each completed line.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_lines = 0;
        end else begin
            if ($countones({LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}) != 0) begin
                check("strobe_onehot",
                      $countones({LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}), 1);
                check("cmd_ready_during_line", cmd_ready, 0);
            end
            if (LE_color_valid) begin
                check("ready_before_color", rdy_q, 1);
                cap_color = LE_color;
                t_c = cyc;
            end
            if (LE_point0_valid) begin
                cap_p0 = LE_point;
                t_0 = cyc;
            end
            if (LE_point1_valid) begin
                if (exp_q.size() == 0) check("stray_point1", LE_point1_valid, 0);
                cap_p1 = LE_point;
                t_1 = cyc;
            end
            if (LE_trigger) begin
                exp_lines++;
                if (exp_q.size() == 0) begin
                    check("unexpected_trigger", LE_trigger, 0);
                end else begin
                    line_t e;
                    e = exp_q.pop_front();
                    check("line_color", cap_color, e.color);
                    check("line_p0", cap_p0, e.p0);
                    check("line_p1", cap_p1, e.p1);
                    check("color_held", LE_color, e.color);
                    check("point_held", LE_point, e.p1);
                    check("strobe_spacing", {t_0 - t_c, t_1 - t_c, cyc - t_c}, {32'd1, 32'd2, 32'd3} );
                    check("lines_drawn", lines_drawn, exp_lines[15:0]);
                    check("lines_drawn_w2", lines_drawn2, exp_lines[1:0]);
                end
            end
            if (done) begin
                n_done++;
                check("done_with_idle", busy, 0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) begin
            cmd_valid = 1'b0;
            cmd_data  = $urandom;
            @(negedge clk);
        end
        cmd_data  = w;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_timeout", cmd_ready, 1);
        end else begin
            @(negedge clk);
            n_sent++;
        end
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
    endtask

    task automatic line_cmd(input logic [31:0] col, input logic [19:0] a,
                            input logic [19:0] b, input int gap);
        exp_q.push_back('{color: col, p0: a, p1: b});
        send_word(32'h0200_0000, gap);
        send_word({12'h000, a}, gap);
        send_word({12'h000, b}, gap);
    endtask

    task automatic stop_cmd();
        exp_done++;
        send_word(32'h0000_0000, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done_bad", {done, bad_opcode}, 0);
        check("rst_color", LE_color, 0);
        check("rst_point", LE_point, 0);
        check("rst_lines", lines_drawn, 0);
        check("rst_strobes", {LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_start", busy, 0);

        // Colour + single line, 20-cycle engine busy, P1 with junk upper bits.
        pulse_start();
        send_word(32'h017F_0000, 0);
        exp_q.push_back('{color: 32'h007F_0000, p0: 20'h00000, p1: 20'hC8000});
        send_word(32'h0200_0000, 0);
        send_word(32'h0000_0000, 0);
        send_word(32'hABCC_8000, 0);
        stop_cmd();
        wait_idle();
        check("t1_lines", lines_drawn, 1);
        check("t1_bad", bad_opcode, 0);

        // New colour, then a four-point polyline.
        eng_cycles = 3;
        pulse_start();
        send_word(32'h0112_3456, 0);
        exp_q.push_back('{color: 32'h0012_3456, p0: pt(0, 0),   p1: pt(10, 10)});
        exp_q.push_back('{color: 32'h0012_3456, p0: pt(10, 10), p1: pt(20, 0)});
        exp_q.push_back('{color: 32'h0012_3456, p0: pt(20, 0),  p1: pt(30, 10)});
        send_word(32'h0300_0004, 0);
        send_word({12'h000, pt(0, 0)}, 0);
        send_word({12'h000, pt(10, 10)}, 0);
        send_word({12'h000, pt(20, 0)}, 0);
        send_word({12'h000, pt(30, 10)}, 0);
        stop_cmd();
        wait_idle();
        check("t2_lines", lines_drawn, 4);

        // Degenerate polylines and an unknown opcode: no lines drawn.
        pulse_start();
        send_word(32'h0300_0000, 0);
        send_word(32'h0300_0001, 0);
        send_word(32'h0001_2345, 0);
        send_word(32'h7F00_0000, 0);
        stop_cmd();
        wait_idle();
        check("t3_bad", bad_opcode, 1);
        check("t3_lines", lines_drawn, 4);

        // Engine not ready for 50 cycles; words arrive with random gaps.
        force_low = 1'b1;
        pulse_start();
        line_cmd(32'h0012_3456, pt(5, 7), pt(1023, 1023), $urandom_range(0, 3));
        repeat (10) @(negedge clk);
        check("t4_ready_blocked", cmd_ready, 0);
        check("t4_no_color", LE_color_valid, 0);
        repeat (40) @(negedge clk);
        force_low = 1'b0;
        stop_cmd();
        wait_idle();
        check("t4_lines", lines_drawn, 5);

        // Reset during the line handshake, with a simultaneous start.
        pulse_start();
        line_cmd(32'h0012_3456, pt(1, 2), pt(3, 4), 0);
        begin
            int n;
            n = 0;
            while (!LE_point0_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("t5_p0_seen", LE_point0_valid, 1);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_strobes", {LE_color_valid, LE_point0_valid, LE_point1_valid, LE_trigger}, 0);
        check("t5_busy", busy, 0);
        check("t5_bad", bad_opcode, 0);
        check("t5_lines", lines_drawn, 0);
        check("t5_color_point", {LE_color, LE_point}, 0);
        check("t5_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle_after", busy, 0);
        check("t5_no_late_strobes", {LE_point1_valid, LE_trigger}, 0);

        // Five single lines after reset: 2-bit counter runs 1,2,3,0,1.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            line_cmd(32'h0000_0000, pt(i, 2 * i), pt(100 + i, 500 - i), 0);
        end
        stop_cmd();
        wait_idle();
        check("t6_lines", lines_drawn, 5);
        check("t6_lines_w2", lines_drawn2, 1);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count", n_done, exp_done);
        check("words_accepted", n_acc, n_sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
